counter_seq_checker: RTL and testbench

//  Receive-side monitor for the free-running Counter4_COUT family: samples the

---
 rtl/counter_chk_pkg.sv | 13 +
 rtl/counter_seq_checker_sat.sv | 32 +++
 rtl/counter_seq_checker.sv | 142 ++++++++++++++
 tb/tb_counter_seq_checker.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/counter_chk_pkg.sv
// Shared types for the counter sequence checker.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package counter_chk_pkg;

    // Checker FSM states, 2-bit encoded.
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACQUIRE = 2'd1,
        ST_LOCKED  = 2'd2
    } chk_state_t;

endpackage

// File: rtl/counter_seq_checker_sat.sv
// Saturating event counter with synchronous clear; clear+inc loads 1.
// Latency: q updates one clock after inc/clr.
// Backpressure: none; sticks at all-ones, further increments are dropped.
//
// Ports: clk, rst_n (async active-low), inc (count one event),
//        clr (sync clear), q (current count).
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] q
);

    logic [W-1:0] r_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q <= '0;
        end else if (clr) begin
            // An event in the same cycle as the clear is kept, not lost.
            r_q <= inc ? W'(1) : '0;
        end else if (inc && (r_q != {W{1'b1}})) begin
            r_q <= r_q + W'(1);
        end
    end

    assign q = r_q;

endmodule

// File: rtl/counter_seq_checker.sv
// Monitor for a free-running counter: checks +1 steps, wrap and COUT, reports lock/errors.
// Latency: all outputs registered, change one CLK after the enabled sample.
// Backpressure: none; EN=0 freezes all state (ERR drops to 0).
//
// Ports: CLK, ASYNCRESETN (async active-low), EN (sample enable), CLR (clear stats),
//        O/COUT (observed counter), LOCKED, ERR (pulse), ERR_STICKY,
//        ERR_COUNT/WRAP_COUNT (saturating), EXPECTED (next predicted O).
module counter_seq_checker
    import counter_chk_pkg::*;
#(
    parameter int WIDTH      = 4,
    parameter int CNT_WIDTH  = 8,
    parameter int LOCK_COUNT = 2,
    parameter int ALLOW_HOLD = 0
) (
    input  logic                 CLK,
    input  logic                 ASYNCRESETN,
    input  logic                 EN,
    input  logic                 CLR,
    input  logic [WIDTH-1:0]     O,
    input  logic                 COUT,
    output logic                 LOCKED,
    output logic                 ERR,
    output logic                 ERR_STICKY,
    output logic [CNT_WIDTH-1:0] ERR_COUNT,
    output logic [CNT_WIDTH-1:0] WRAP_COUNT,
    output logic [WIDTH-1:0]     EXPECTED
);

    // Good-transition counter only needs to reach LOCK_COUNT.
    localparam int GW = (LOCK_COUNT < 1) ? 1 : $clog2(LOCK_COUNT + 1);
    localparam logic [WIDTH-1:0] MAX_VAL = {WIDTH{1'b1}};

    chk_state_t     r_state, w_state_nxt;
    logic [WIDTH-1:0] r_prev, w_prev_nxt;
    logic [GW-1:0]  r_good_cnt, w_good_nxt;
    logic [WIDTH-1:0] r_expected, w_expected_nxt;
    logic           r_err;
    logic           r_sticky;

    logic [WIDTH-1:0] w_pred;
    logic [GW-1:0]  w_good_inc;
    logic           w_step, w_hold, w_cout_ok, w_legal;
    logic           w_err_ev, w_wrap_ev;

    assign w_pred     = r_prev + WIDTH'(1);
    assign w_good_inc = r_good_cnt + GW'(1);
    assign w_step     = (O == w_pred);
    assign w_hold     = (ALLOW_HOLD != 0) && (O == r_prev);
    assign w_cout_ok  = (COUT == (O == MAX_VAL));
    assign w_legal    = (w_step || w_hold) && w_cout_ok;

    assign w_err_ev  = EN && (r_state == ST_LOCKED) && !w_legal;
    // A hold at MAX is legal but is not a wrap; require the real MAX->0 step.
    assign w_wrap_ev = EN && (r_state == ST_LOCKED) && w_legal && w_step &&
                       (r_prev == MAX_VAL);

    always_comb begin
        w_state_nxt = r_state;
        w_prev_nxt  = r_prev;
        w_good_nxt  = r_good_cnt;
        if (EN) begin
            case (r_state)
                ST_IDLE: begin
                    w_prev_nxt  = O;
                    w_good_nxt  = '0;
                    w_state_nxt = ST_ACQUIRE;
                end
                ST_ACQUIRE: begin
                    if (!w_legal) begin
                        w_prev_nxt = O;
                        w_good_nxt = '0;
                    end else if (w_step) begin
                        // Holds are tolerated but do not count toward lock.
                        w_prev_nxt = O;
                        w_good_nxt = w_good_inc;
                        if (w_good_inc >= GW'(LOCK_COUNT)) begin
                            w_state_nxt = ST_LOCKED;
                        end
                    end
                end
                ST_LOCKED: begin
                    w_prev_nxt = O;
                    if (!w_legal) begin
                        // Resync on the observed value.
                        w_good_nxt  = '0;
                        w_state_nxt = ST_ACQUIRE;
                    end
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                end
            endcase
        end
        w_expected_nxt = (w_state_nxt == ST_IDLE) ? '0 : (w_prev_nxt + WIDTH'(1));
    end

    always_ff @(posedge CLK or negedge ASYNCRESETN) begin
        if (!ASYNCRESETN) begin
            r_state    <= ST_IDLE;
            r_prev     <= '0;
            r_good_cnt <= '0;
            r_expected <= '0;
            r_err      <= 1'b0;
            r_sticky   <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_prev     <= w_prev_nxt;
            r_good_cnt <= w_good_nxt;
            r_expected <= w_expected_nxt;
            r_err      <= w_err_ev;
            // Error in the same cycle as CLR wins.
            if (w_err_ev) begin
                r_sticky <= 1'b1;
            end else if (CLR) begin
                r_sticky <= 1'b0;
            end
        end
    end

    sat_counter #(.W(CNT_WIDTH)) u_err_cnt (
        .clk   (CLK),
        .rst_n (ASYNCRESETN),
        .inc   (w_err_ev),
        .clr   (CLR),
        .q     (ERR_COUNT)
    );

    sat_counter #(.W(CNT_WIDTH)) u_wrap_cnt (
        .clk   (CLK),
        .rst_n (ASYNCRESETN),
        .inc   (w_wrap_ev),
        .clr   (CLR),
        .q     (WRAP_COUNT)
    );

    assign LOCKED     = (r_state == ST_LOCKED);
    assign ERR        = r_err;
    assign ERR_STICKY = r_sticky;
    assign EXPECTED   = r_expected;

endmodule

// File: tb/tb_counter_seq_checker.sv
// Directed bench for counter_seq_checker: default, hold-tolerant and 2-bit-stat instances.
// Latency: outputs compared on the falling edge after each sampled rising edge.
// Backpressure: n/a.
module tb_counter_seq_checker;

    logic       CLK = 1'b0;
    logic       ASYNCRESETN = 1'b0;
    logic       EN = 1'b0;
    logic       CLR = 1'b0;
    logic [3:0] O = '0;
    logic       COUT = 1'b0;

    logic       a_locked, a_err, a_sticky;
    logic [7:0] a_ecnt, a_wcnt;
    logic [3:0] a_exp;
    logic       b_locked, b_err, b_sticky;
    logic [7:0] b_ecnt, b_wcnt;
    logic [3:0] b_exp;
    logic       c_locked, c_err, c_sticky;
    logic [1:0] c_ecnt, c_wcnt;
    logic [3:0] c_exp;

    int n_checks = 0;
    int n_errors = 0;

    always #5 CLK = ~CLK;

    counter_seq_checker #(.WIDTH(4), .CNT_WIDTH(8), .LOCK_COUNT(2), .ALLOW_HOLD(0)) u_dut_a (
        .CLK(CLK), .ASYNCRESETN(ASYNCRESETN), .EN(EN), .CLR(CLR), .O(O), .COUT(COUT),
        .LOCKED(a_locked), .ERR(a_err), .ERR_STICKY(a_sticky),
        .ERR_COUNT(a_ecnt), .WRAP_COUNT(a_wcnt), .EXPECTED(a_exp)
    );

    counter_seq_checker #(.WIDTH(4), .CNT_WIDTH(8), .LOCK_COUNT(2), .ALLOW_HOLD(1)) u_dut_b (
        .CLK(CLK), .ASYNCRESETN(ASYNCRESETN), .EN(EN), .CLR(CLR), .O(O), .COUT(COUT),
        .LOCKED(b_locked), .ERR(b_err), .ERR_STICKY(b_sticky),
        .ERR_COUNT(b_ecnt), .WRAP_COUNT(b_wcnt), .EXPECTED(b_exp)
    );

    counter_seq_checker #(.WIDTH(4), .CNT_WIDTH(2), .LOCK_COUNT(2), .ALLOW_HOLD(0)) u_dut_c (
        .CLK(CLK), .ASYNCRESETN(ASYNCRESETN), .EN(EN), .CLR(CLR), .O(O), .COUT(COUT),
        .LOCKED(c_locked), .ERR(c_err), .ERR_STICKY(c_sticky),
        .ERR_COUNT(c_ecnt), .WRAP_COUNT(c_wcnt), .EXPECTED(c_exp)
    );

    typedef struct {
        logic       en;
        logic       clr;
        logic [3:0] o;
        logic       cout;
        logic       locked;
        logic       err;
        logic       sticky;
        int         ecnt;
        int         wcnt;
        int         expct;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic en, input logic clr, input int o, input logic cout,
                       input logic locked, input logic err, input logic sticky,
                       input int ecnt, input int wcnt, input int expct);
        vec_t v;
        v.en = en; v.clr = clr; v.o = 4'(o); v.cout = cout;
        v.locked = locked; v.err = err; v.sticky = sticky;
        v.ecnt = ecnt; v.wcnt = wcnt; v.expct = expct;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input int act, input int req);
        n_checks++;
        if (act != req) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    // Inputs change on the falling edge; results are read one full cycle later.
    task automatic drive(input logic en, input logic clr, input logic [3:0] o, input logic cout);
        EN = en; CLR = clr; O = o; COUT = cout;
        @(posedge CLK);
        @(negedge CLK);
    endtask

    task automatic do_reset();
        EN = 1'b0; CLR = 1'b0; O = '0; COUT = 1'b0;
        ASYNCRESETN = 1'b0;
        @(negedge CLK);
        @(negedge CLK);
        ASYNCRESETN = 1'b1;
    endtask

    initial begin
        logic [3:0] v;

        // en clr  o cout | locked err sticky ecnt wcnt expected
        add(1,0, 0,0, 0,0,0,0,0, 1);
        add(1,0, 1,0, 0,0,0,0,0, 2);
        add(1,0, 2,0, 1,0,0,0,0, 3);   // lock after second good step
        add(1,0, 3,0, 1,0,0,0,0, 4);
        add(1,0, 4,0, 1,0,0,0,0, 5);
        add(1,0, 5,0, 1,0,0,0,0, 6);
        add(1,0, 7,0, 0,1,1,1,0, 8);   // skip -> error, resync at 7
        add(1,0, 8,0, 0,0,1,1,0, 9);
        add(1,0, 9,0, 1,0,1,1,0,10);
        add(1,0,10,0, 1,0,1,1,0,11);
        add(1,0,11,0, 1,0,1,1,0,12);
        add(1,0,12,0, 1,0,1,1,0,13);
        add(1,0,13,0, 1,0,1,1,0,14);
        add(1,0,14,0, 1,0,1,1,0,15);
        add(1,0,15,1, 1,0,1,1,0, 0);
        add(1,0, 0,0, 1,0,1,1,1, 1);   // wrap counted
        add(1,0, 1,0, 1,0,1,1,1, 2);
        add(0,0, 9,0, 1,0,1,1,1, 2);   // EN=0: garbage ignored
        add(0,0, 3,1, 1,0,1,1,1, 2);
        add(0,0, 2,0, 1,0,1,1,1, 2);
        add(1,0, 2,0, 1,0,1,1,1, 3);   // no implicit +1 across stall
        add(1,0, 3,1, 0,1,1,2,1, 4);   // bad COUT
        add(1,0, 4,0, 0,0,1,2,1, 5);
        add(1,0, 5,0, 1,0,1,2,1, 6);
        add(1,0, 5,0, 0,1,1,3,1, 6);   // hold illegal without ALLOW_HOLD
        add(1,0, 6,0, 0,0,1,3,1, 7);
        add(1,0, 7,0, 1,0,1,3,1, 8);
        add(1,1, 8,0, 1,0,0,0,0, 9);   // CLR
        add(1,0, 9,0, 1,0,0,0,0,10);
        add(1,1,11,0, 0,1,1,1,0,12);   // CLR with error: error wins
        add(1,0,12,0, 0,0,1,1,0,13);
        add(1,0,13,0, 1,0,1,1,0,14);
        add(1,0,14,0, 1,0,1,1,0,15);
        add(1,1,15,1, 1,0,0,0,0, 0);
        add(1,1, 0,0, 1,0,0,0,1, 1);   // CLR with wrap -> 1

        do_reset();
        @(negedge CLK);
        chk("reset LOCKED", int'(a_locked), 0);
        chk("reset ERR", int'(a_err), 0);
        chk("reset ERR_STICKY", int'(a_sticky), 0);
        chk("reset ERR_COUNT", int'(a_ecnt), 0);
        chk("reset WRAP_COUNT", int'(a_wcnt), 0);
        chk("reset EXPECTED", int'(a_exp), 0);

        foreach (vecs[i]) begin
            drive(vecs[i].en, vecs[i].clr, vecs[i].o, vecs[i].cout);
            chk($sformatf("row%0d LOCKED", i), int'(a_locked), int'(vecs[i].locked));
            chk($sformatf("row%0d ERR", i), int'(a_err), int'(vecs[i].err));
            chk($sformatf("row%0d ERR_STICKY", i), int'(a_sticky), int'(vecs[i].sticky));
            chk($sformatf("row%0d ERR_COUNT", i), int'(a_ecnt), vecs[i].ecnt);
            chk($sformatf("row%0d WRAP_COUNT", i), int'(a_wcnt), vecs[i].wcnt);
            chk($sformatf("row%0d EXPECTED", i), int'(a_exp), vecs[i].expct);
        end

        // Asynchronous reset between clock edges while locked.
        EN = 1'b0; CLR = 1'b0;
        chk("pre-arst LOCKED", int'(a_locked), 1);
        #2 ASYNCRESETN = 1'b0;
        #1;
        chk("arst LOCKED", int'(a_locked), 0);
        chk("arst WRAP_COUNT", int'(a_wcnt), 0);
        chk("arst EXPECTED", int'(a_exp), 0);
        chk("arst ERR_STICKY", int'(a_sticky), 0);
        @(negedge CLK);
        ASYNCRESETN = 1'b1;

        // Hold-tolerant instance: holds never lock or error.
        do_reset();
        drive(1,0,0,0); drive(1,0,0,0); drive(1,0,0,0); drive(1,0,1,0);
        chk("hold acquire no lock", int'(b_locked), 0);
        drive(1,0,2,0);
        chk("hold acquire lock", int'(b_locked), 1);
        drive(1,0,3,0);
        drive(1,0,4,0);
        chk("hold step ERR", int'(b_err), 0);
        drive(1,0,4,0);
        chk("hold repeat ERR", int'(b_err), 0);
        chk("hold repeat LOCKED", int'(b_locked), 1);
        drive(1,0,5,0);
        chk("hold resume ERR", int'(b_err), 0);
        chk("hold ERR_COUNT", int'(b_ecnt), 0);
        chk("hold EXPECTED", int'(b_exp), 6);

        // 2-bit statistics instance: saturation and clear-with-error.
        do_reset();
        drive(1,0,0,0); drive(1,0,1,0); drive(1,0,2,0);
        v = 4'd2;
        chk("sat initial LOCKED", int'(c_locked), 1);
        for (int k = 0; k < 5; k++) begin
            v = v + 4'd5;
            drive(1,0,v,(v == 4'd15));
            chk($sformatf("sat err%0d ERR", k), int'(c_err), 1);
            v = v + 4'd1;
            drive(1,0,v,(v == 4'd15));
            v = v + 4'd1;
            drive(1,0,v,(v == 4'd15));
            chk($sformatf("sat err%0d relock", k), int'(c_locked), 1);
        end
        chk("sat ERR_COUNT", int'(c_ecnt), 3);
        v = v + 4'd5;
        drive(1,1,v,(v == 4'd15));
        chk("sat clr+err ERR_COUNT", int'(c_ecnt), 1);
        chk("sat clr+err ERR_STICKY", int'(c_sticky), 1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
